// File: rtl/fma16_result_stage.sv
// fma16_result_stage
// Registered output stage behind the fp16 FMA special-case logic. It holds
// results in a 2-entry skid buffer: head H drives the outputs, and skid S
// takes an entry while H is stalled. It also keeps the sticky exception flags
// and counts retired operations.
module fma16_result_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_result,
  input  logic [3:0]       in_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_result,
  output logic [3:0]       out_flags,
  input  logic             flush,
  input  logic             fflags_we,
  input  logic [4:0]       fflags_wdata,
  output logic [4:0]       fflags,
  output logic [CNT_W-1:0] retired_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occState_e;

  occState_e        occState;
  occState_e        occNext;
  logic [15:0]      headResult;
  logic [3:0]       headFlags;
  logic [15:0]      skidResult;
  logic [3:0]       skidFlags;
  logic [4:0]       stickyFlags;
  logic [CNT_W-1:0] retireCount;
  logic             accept;
  logic             retire;
  logic             loadHeadFromIn;
  logic             loadHeadFromSkid;
  logic             loadSkid;
  logic [4:0]       retireFlags;

  // Valid and ready both come straight from the occupancy register, so
  // in_ready has no combinational path from out_ready.
  assign out_valid   = (occState != EMPTY);
  assign in_ready    = (occState != FULL);
  assign out_result  = headResult;
  assign out_flags   = headFlags;
  assign fflags      = stickyFlags;
  assign retired_cnt = retireCount;

  assign accept      = in_valid & in_ready;
  assign retire      = out_valid & out_ready;
  assign retireFlags = {headFlags[3], 1'b0, headFlags[2], headFlags[1], headFlags[0]};

  // Occupancy state register
  always_ff @(posedge clk) begin
    if (reset) begin
      occState <= EMPTY;
    end else begin
      occState <= occNext;
    end
  end

  // Next occupancy and which storage register loads. Flush empties the buffer
  // and drops any entry accepted in the same cycle.
  always_comb begin
    occNext          = occState;
    loadHeadFromIn   = 1'b0;
    loadHeadFromSkid = 1'b0;
    loadSkid         = 1'b0;
    unique case (occState)
      EMPTY: begin
        if (accept) begin
          occNext        = ONE;
          loadHeadFromIn = 1'b1;
        end
      end
      ONE: begin
        if (accept && retire) begin
          loadHeadFromIn = 1'b1;
        end else if (accept) begin
          occNext  = FULL;
          loadSkid = 1'b1;
        end else if (retire) begin
          occNext = EMPTY;
        end
      end
      FULL: begin
        if (retire) begin
          occNext          = ONE;
          loadHeadFromSkid = 1'b1;
        end
      end
      default: begin
        occNext = EMPTY;
      end
    endcase
    if (flush) begin
      occNext          = EMPTY;
      loadHeadFromIn   = 1'b0;
      loadHeadFromSkid = 1'b0;
      loadSkid         = 1'b0;
    end
  end

  // Head and skid data registers. Contents are held when nothing loads, so
  // the outputs stay stable under backpressure.
  always_ff @(posedge clk) begin
    if (reset) begin
      headResult <= 16'h0000;
      headFlags  <= 4'h0;
      skidResult <= 16'h0000;
      skidFlags  <= 4'h0;
    end else begin
      if (loadHeadFromIn) begin
        headResult <= in_result;
        headFlags  <= in_flags;
      end else if (loadHeadFromSkid) begin
        headResult <= skidResult;
        headFlags  <= skidFlags;
      end
      if (loadSkid) begin
        skidResult <= in_result;
        skidFlags  <= in_flags;
      end
    end
  end

  // Sticky flags. A CSR write merges with flags retiring in the same cycle,
  // so no exception is lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      stickyFlags <= 5'h00;
    end else if (fflags_we) begin
      stickyFlags <= fflags_wdata | (retire ? retireFlags : 5'h00);
    end else if (retire) begin
      stickyFlags <= stickyFlags | retireFlags;
    end
  end

  // Retired-operation counter. It wraps naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (reset) begin
      retireCount <= '0;
    end else if (retire) begin
      retireCount <= retireCount + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fma16_result_stage.sv
// tb_fma16_result_stage
// Table-driven check of the result stage, plus streaming and counter-wrap
// sequences. Two instances share the stimulus: one with a 16-bit counter and
// one with a 4-bit counter.
module tb_fma16_result_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        inValid;
  logic [15:0] inResult;
  logic [3:0]  inFlags;
  logic        outReady;
  logic        flush;
  logic        fflagsWe;
  logic [4:0]  fflagsWdata;

  logic        inReadyW, outValidW;
  logic [15:0] outResultW;
  logic [3:0]  outFlagsW;
  logic [4:0]  fflagsW;
  logic [15:0] cntW;

  logic        inReadyN, outValidN;
  logic [15:0] outResultN;
  logic [3:0]  outFlagsN;
  logic [4:0]  fflagsN;
  logic [3:0]  cntN;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  fma16_result_stage #(.CNT_W(16)) dutWide (
    .clk(clk), .reset(reset), .in_valid(inValid), .in_ready(inReadyW),
    .in_result(inResult), .in_flags(inFlags), .out_valid(outValidW),
    .out_ready(outReady), .out_result(outResultW), .out_flags(outFlagsW),
    .flush(flush), .fflags_we(fflagsWe), .fflags_wdata(fflagsWdata),
    .fflags(fflagsW), .retired_cnt(cntW)
  );

  fma16_result_stage #(.CNT_W(4)) dutNarrow (
    .clk(clk), .reset(reset), .in_valid(inValid), .in_ready(inReadyN),
    .in_result(inResult), .in_flags(inFlags), .out_valid(outValidN),
    .out_ready(outReady), .out_result(outResultN), .out_flags(outFlagsN),
    .flush(flush), .fflags_we(fflagsWe), .fflags_wdata(fflagsWdata),
    .fflags(fflagsN), .retired_cnt(cntN)
  );

  typedef struct packed {
    logic        rst;
    logic        inValid;
    logic [15:0] inResult;
    logic [3:0]  inFlags;
    logic        outReady;
    logic        flush;
    logic        we;
    logic [4:0]  wdata;
    logic        chkData;
    logic        expOutValid;
    logic        expInReady;
    logic [15:0] expResult;
    logic [3:0]  expFlags;
    logic [4:0]  expFflags;
    logic [15:0] expCnt;
  } vec_t;

  vec_t vecs [19];

  function automatic vec_t mk(logic rst, logic iv, logic [15:0] ir, logic [3:0] ifl,
                              logic ordy, logic fl, logic we, logic [4:0] wd,
                              logic chk, logic eov, logic eir, logic [15:0] eres,
                              logic [3:0] efl, logic [4:0] eff, logic [15:0] ecnt);
    vec_t v;
    v = '{rst, iv, ir, ifl, ordy, fl, we, wd, chk, eov, eir, eres, efl, eff, ecnt};
    return v;
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    reset       = v.rst;
    inValid     = v.inValid;
    inResult    = v.inResult;
    inFlags     = v.inFlags;
    outReady    = v.outReady;
    flush       = v.flush;
    fflagsWe    = v.we;
    fflagsWdata = v.wdata;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input int row, input vec_t v);
    checkVal($sformatf("row%0d out_valid", row), 32'(outValidW), 32'(v.expOutValid));
    checkVal($sformatf("row%0d in_ready", row), 32'(inReadyW), 32'(v.expInReady));
    if (v.chkData) begin
      checkVal($sformatf("row%0d out_result", row), 32'(outResultW), 32'(v.expResult));
      checkVal($sformatf("row%0d out_flags", row), 32'(outFlagsW), 32'(v.expFlags));
    end
    checkVal($sformatf("row%0d fflags", row), 32'(fflagsW), 32'(v.expFflags));
    checkVal($sformatf("row%0d retired_cnt", row), 32'(cntW), 32'(v.expCnt));
    checkVal($sformatf("row%0d narrow cnt", row), 32'(cntN), 32'(v.expCnt[3:0]));
  endtask

  task automatic doReset();
    reset = 1'b1; inValid = 1'b0; outReady = 1'b0; flush = 1'b0;
    fflagsWe = 1'b0; fflagsWdata = 5'h00; inResult = 16'h0000; inFlags = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Back-to-back ops with out_ready high; each op shows up one cycle after it is accepted.
  task automatic streamOps(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      inValid  = 1'b1;
      outReady = 1'b1;
      inResult = 16'h1000 + 16'(i);
      inFlags  = 4'(i);
      @(posedge clk);
      #1;
      checkVal($sformatf("%s op%0d out_valid", tag, i), 32'(outValidW), 32'h1);
      checkVal($sformatf("%s op%0d in_ready", tag, i), 32'(inReadyW), 32'h1);
      checkVal($sformatf("%s op%0d out_result", tag, i), 32'(outResultW), 32'h1000 + 32'(i));
      checkVal($sformatf("%s op%0d out_flags", tag, i), 32'(outFlagsW), 32'(i % 16));
    end
    inValid = 1'b0;
    @(posedge clk);
    #1;
    checkVal($sformatf("%s drained out_valid", tag), 32'(outValidW), 32'h0);
  endtask

  initial begin
    // rst iv  inRes    fl    ordy fl we wd      chk eov eir expRes   efl   eff    cnt
    vecs[0]  = mk(1, 1, 16'h1234, 4'h3, 0, 0, 0, 5'h00, 1, 0, 1, 16'h0000, 4'h0, 5'h00, 16'd0);
    vecs[1]  = mk(1, 1, 16'h1234, 4'h3, 0, 0, 0, 5'h00, 1, 0, 1, 16'h0000, 4'h0, 5'h00, 16'd0);
    vecs[2]  = mk(0, 1, 16'h3C00, 4'h0, 1, 0, 0, 5'h00, 1, 1, 1, 16'h3C00, 4'h0, 5'h00, 16'd0);
    vecs[3]  = mk(0, 0, 16'h0000, 4'h0, 1, 0, 0, 5'h00, 0, 0, 1, 16'h0000, 4'h0, 5'h00, 16'd1);
    vecs[4]  = mk(0, 1, 16'h7C00, 4'h5, 0, 0, 0, 5'h00, 1, 1, 1, 16'h7C00, 4'h5, 5'h00, 16'd1);
    vecs[5]  = mk(0, 1, 16'h7E00, 4'h8, 0, 0, 0, 5'h00, 1, 1, 0, 16'h7C00, 4'h5, 5'h00, 16'd1);
    vecs[6]  = mk(0, 1, 16'h1111, 4'h2, 0, 0, 0, 5'h00, 1, 1, 0, 16'h7C00, 4'h5, 5'h00, 16'd1);
    vecs[7]  = mk(0, 1, 16'h1111, 4'h2, 1, 0, 0, 5'h00, 1, 1, 1, 16'h7E00, 4'h8, 5'h05, 16'd2);
    vecs[8]  = mk(0, 0, 16'h0000, 4'h0, 1, 0, 0, 5'h00, 0, 0, 1, 16'h0000, 4'h0, 5'h15, 16'd3);
    vecs[9]  = mk(0, 0, 16'h0000, 4'h0, 0, 0, 1, 5'h00, 0, 0, 1, 16'h0000, 4'h0, 5'h00, 16'd3);
    vecs[10] = mk(0, 1, 16'h4000, 4'h1, 0, 0, 0, 5'h00, 1, 1, 1, 16'h4000, 4'h1, 5'h00, 16'd3);
    vecs[11] = mk(0, 0, 16'h0000, 4'h0, 1, 0, 1, 5'h08, 0, 0, 1, 16'h0000, 4'h0, 5'h09, 16'd4);
    vecs[12] = mk(0, 0, 16'h0000, 4'h0, 0, 0, 1, 5'h00, 0, 0, 1, 16'h0000, 4'h0, 5'h00, 16'd4);
    vecs[13] = mk(0, 1, 16'hA000, 4'h2, 0, 0, 0, 5'h00, 1, 1, 1, 16'hA000, 4'h2, 5'h00, 16'd4);
    vecs[14] = mk(0, 1, 16'hB000, 4'h4, 0, 0, 0, 5'h00, 1, 1, 0, 16'hA000, 4'h2, 5'h00, 16'd4);
    vecs[15] = mk(0, 1, 16'hC000, 4'h1, 0, 1, 0, 5'h00, 0, 0, 1, 16'h0000, 4'h0, 5'h00, 16'd4);
    vecs[16] = mk(0, 1, 16'hD000, 4'h2, 0, 0, 0, 5'h00, 1, 1, 1, 16'hD000, 4'h2, 5'h00, 16'd4);
    vecs[17] = mk(0, 1, 16'hE000, 4'h8, 1, 1, 0, 5'h00, 0, 0, 1, 16'h0000, 4'h0, 5'h02, 16'd5);
    vecs[18] = mk(0, 0, 16'h0000, 4'h0, 1, 0, 0, 5'h00, 0, 0, 1, 16'h0000, 4'h0, 5'h02, 16'd5);

    for (int r = 0; r < 19; r++) begin
      applyStimulus(vecs[r]);
      checkOutput(r, vecs[r]);
    end

    // Streaming: 100 ops, one per cycle, in order
    doReset();
    streamOps(100, "stream");
    checkVal("stream retired_cnt", 32'(cntW), 32'd100);
    checkVal("stream narrow cnt", 32'(cntN), 32'd4);
    checkVal("stream fflags", 32'(fflagsW), 32'h17);

    // Counter wrap: 17 retires on the 4-bit counter wraps it to 1
    doReset();
    streamOps(17, "wrap");
    checkVal("wrap narrow cnt", 32'(cntN), 32'd1);
    checkVal("wrap wide cnt", 32'(cntW), 32'd17);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
